demux4_buf: RTL and testbench

- 1-to-4 buffered demultiplexer; the counterpart of the 4:1 result selector.
- Takes one producer stream with a 2-bit destination select and routes each word to one of four consumer channels.
- Each channel has its own small FIFO, so a stalled consumer does not block words bound for the other channels once they are accepted.
- Sits between a single result source (ALU or write-back) and four independent sinks.

---
 rtl/demux4_buf.sv | 75 +++++++
 tb/tb_demux4_buf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/demux4_buf.sv
// 1-to-4 buffered demultiplexer: one producer stream is routed by in_sel into
// four independent per-channel FIFOs, each drained by its own consumer.
module demux4_buf #(
  parameter int DATASIZE = 16,
  parameter int DEPTH    = 2,
  parameter int PTRW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [DATASIZE-1:0] in_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [DATASIZE-1:0] out_data0,
  output logic [DATASIZE-1:0] out_data1,
  output logic [DATASIZE-1:0] out_data2,
  output logic [DATASIZE-1:0] out_data3,
  output logic                busy
);

  // Handshake: a word moves on any side only in a cycle where valid and ready
  // are both high at the rising edge. in_ready depends only on in_sel and
  // registered counts, never on in_valid or out_ready.

  logic [3:0]          w_full;
  logic [3:0]          w_push;
  logic [3:0]          w_pop;
  logic [DATASIZE-1:0] w_head [4];

  assign in_ready = !w_full[in_sel];
  assign busy     = |out_valid;

  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [PTRW:0]       r_count;
    logic [PTRW-1:0]     r_rd_ptr;
    logic [PTRW-1:0]     r_wr_ptr;

    assign w_full[k]    = (r_count == (PTRW+1)'(DEPTH));
    assign out_valid[k] = (r_count != '0);
    assign w_push[k]    = in_valid && in_ready && (in_sel == 2'(k));
    assign w_pop[k]     = out_valid[k] && out_ready[k];
    assign w_head[k]    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push[k]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[k])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage is deliberately left out of reset; out_valid masks stale words.
    always_ff @(posedge clk) begin
      if (w_push[k]) r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf: reset, fan-out, full/backpressure, concurrent
// push/pop, pointer wrap, and asynchronous reset discard.
module tb_demux4_buf;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  demux4_buf #(.DATASIZE(W), .DEPTH(2), .PTRW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [W-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: reset state
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
    end

    // 2: fan-out to all four channels
    push(2'd0, 16'h1111);
    push(2'd1, 16'h2222);
    push(2'd2, 16'h3333);
    push(2'd3, 16'h4444);
    chk("fan_out_valid", 32'(out_valid), 32'hf);
    chk("fan_busy", 32'(busy), 32'h1);
    chk("fan_data0", 32'(out_data0), 32'h1111);
    chk("fan_data1", 32'(out_data1), 32'h2222);
    chk("fan_data2", 32'(out_data2), 32'h3333);
    chk("fan_data3", 32'(out_data3), 32'h4444);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("fan_drained", 32'(out_valid), 32'h0);

    // 3: fill channel 2, reject third word, drain in order
    push(2'd2, 16'hA001);
    push(2'd2, 16'hA002);
    in_sel = 2'd2;
    #1;
    chk("full_ready_sel2", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1;
    chk("full_ready_sel0", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 16'hA003;
    out_ready[2] = 1'b1;
    #1;
    chk("full_ready_with_pop", 32'(in_ready), 32'h0);
    out_ready[2] = 1'b0;
    step();
    in_valid = 1'b0;
    chk("full_head0", 32'(out_data2), 32'hA001);
    out_ready = 4'b0100;
    step();
    chk("full_valid1", 32'(out_valid[2]), 32'h1);
    chk("full_head1", 32'(out_data2), 32'hA002);
    step();
    chk("full_empty", 32'(out_valid[2]), 32'h0);
    out_ready = 4'b0000;

    // 4: simultaneous push/pop on channel 1 holding one word
    push(2'd1, 16'h1234);
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 16'hBEEF;
    #1;
    chk("pp_ready", 32'(in_ready), 32'h1);
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("pp_valid", 32'(out_valid), 32'h2);
    chk("pp_data1", 32'(out_data1), 32'hBEEF);
    out_ready = 4'b0010;
    step();
    out_ready = 4'b0000;
    chk("pp_count_one", 32'(out_valid), 32'h0);

    // 5: stream through channel 3 with pointer wrap
    out_ready = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 16'h5000 + 16'(i);
      #1;
      chk($sformatf("stream_ready%0d", i), 32'(in_ready), 32'h1);
      if (in_ready) exp_q.push_back(in_data);
      step();
      in_valid = 1'b0;
      chk($sformatf("stream_valid%0d", i), 32'(out_valid[3]), 32'h1);
      if (exp_q.size() > 0)
        chk($sformatf("stream_data%0d", i), 32'(out_data3), 32'(exp_q.pop_front()));
    end
    step();
    out_ready = 4'b0000;
    chk("stream_empty", 32'(out_valid), 32'h0);
    chk("stream_q_empty", 32'(exp_q.size()), 32'h0);

    // 6: asynchronous reset with buffered words
    push(2'd0, 16'hC001);
    push(2'd1, 16'hC002);
    chk("arst_pre", 32'(out_valid), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("arst_no_stale", 32'(out_valid), 32'h0);
    push(2'd0, 16'hD00D);
    chk("arst_post_valid", 32'(out_valid), 32'h1);
    chk("arst_post_data", 32'(out_data0), 32'hD00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
